// File: rtl/spi_pkg.sv
// Shared definitions for the SPI minion front end: FSM states,
// header bit positions within the 2-bit frame header and the MISO marker.
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE,
      COMMIT
   } state_e;

   // Positions inside the 2-bit header {W, R}: W arrives first.
   localparam int W_BIT = 1;
   localparam int R_BIT = 0;

   // Two leading bits shifted out ahead of the queue head payload.
   localparam logic [1:0] MISO_MARKER = 2'b10;

endpackage

// File: rtl/spi_minion_frontend_if.sv
// Bundles the SPI pins and the packet-queue controls of the minion front end.
// The slave modport is the front end itself; master is the environment around it.
interface spi_minion_frontend_if #(
   parameter int pack_size = 32
);

   logic                 spi_cs_n;
   logic                 spi_sclk;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic                 serve;
   logic                 hard_msg;
   logic [pack_size-1:0] from_master;
   logic                 seize;
   logic [pack_size-1:0] to_master;

   modport slave (
      input  spi_cs_n,
      input  spi_sclk,
      input  spi_mosi,
      input  to_master,
      output spi_miso,
      output serve,
      output hard_msg,
      output from_master,
      output seize
   );

   modport master (
      output spi_cs_n,
      output spi_sclk,
      output spi_mosi,
      output to_master,
      input  spi_miso,
      input  serve,
      input  hard_msg,
      input  from_master,
      input  seize
   );

endinterface

// File: rtl/spi_synchronizer.sv
// Two-flop synchronizer for one asynchronous pin, plus a history flop so the
// synchronized level can be turned into single-cycle rise/fall strobes.
module spi_synchronizer (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic hist_q;

   // Metastability chain followed by the history flop used for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         s1_q   <= din_i;
         s2_q   <= s1_q;
         hist_q <= s2_q;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = s2_q & ~hist_q;
   assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI minion front end: turns one chip-select window into one fixed-length
// frame {W, R, payload}, shifts the queue head out on MISO and emits the
// push (serve/hard_msg/from_master) and pop (seize) controls at frame end.
module spi_minion_frontend
   import spi_pkg::*;
#(
   parameter int pack_size = 32
) (
   input logic                  clk,
   input logic                  reset,
   spi_minion_frontend_if.slave bus
);

   localparam int FRAME = pack_size + 2;
   localparam int CW    = $clog2(FRAME + 2);

   logic csSync;
   logic csRise;
   logic csFall;
   logic sclkRise;
   logic sclkFall;
   logic mosiSync;

   state_e               state_q,      state_d;
   logic [CW-1:0]        bitCnt_q,     bitCnt_d;
   logic [FRAME-1:0]     shiftIn_q,    shiftIn_d;
   logic [FRAME-1:0]     shiftOut_q,   shiftOut_d;
   logic [pack_size-1:0] fromMaster_q, fromMaster_d;

   logic       wellFormed;
   logic [1:0] header;
   logic       hardMsg;
   logic       readReq;

   spi_synchronizer u_syncCs (
      .clk    (clk),
      .reset  (reset),
      .din_i  (bus.spi_cs_n),
      .sync_o (csSync),
      .rise_o (csRise),
      .fall_o (csFall)
   );

   spi_synchronizer u_syncSclk (
      .clk    (clk),
      .reset  (reset),
      .din_i  (bus.spi_sclk),
      .sync_o (),
      .rise_o (sclkRise),
      .fall_o (sclkFall)
   );

   spi_synchronizer u_syncMosi (
      .clk    (clk),
      .reset  (reset),
      .din_i  (bus.spi_mosi),
      .sync_o (mosiSync),
      .rise_o (),
      .fall_o ()
   );

   // Frame decode from the captured bits; a saturated count never matches FRAME.
   assign wellFormed = (bitCnt_q == CW'(FRAME));
   assign header     = shiftIn_q[FRAME-1 -: 2];
   assign hardMsg    = !(wellFormed && header[W_BIT]);
   assign readReq    = wellFormed && header[R_BIT];

   // State, bit counter, shift registers and the held payload.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_IDLE;
         bitCnt_q     <= '0;
         shiftIn_q    <= '0;
         shiftOut_q   <= '0;
         fromMaster_q <= '0;
      end else begin
         state_q      <= state_d;
         bitCnt_q     <= bitCnt_d;
         shiftIn_q    <= shiftIn_d;
         shiftOut_q   <= shiftOut_d;
         fromMaster_q <= fromMaster_d;
      end
   end

   // Next-state logic: after reset wait for a released chip select so a frame
   // that was cut by reset is never picked up halfway through.
   always_comb begin
      state_d      = state_q;
      bitCnt_d     = bitCnt_q;
      shiftIn_d    = shiftIn_q;
      shiftOut_d   = shiftOut_q;
      fromMaster_d = fromMaster_q;
      case (state_q)
         WAIT_IDLE: begin
            if (csSync) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (csFall) begin
               state_d    = ACTIVE;
               bitCnt_d   = '0;
               shiftIn_d  = '0;
               shiftOut_d = {MISO_MARKER, bus.to_master};
            end
         end
         ACTIVE: begin
            if (csRise) begin
               state_d = COMMIT;
               if (!hardMsg) begin
                  fromMaster_d = shiftIn_q[pack_size-1:0];
               end
            end else begin
               if (sclkRise) begin
                  shiftIn_d = {shiftIn_q[FRAME-2:0], mosiSync};
                  if (bitCnt_q != CW'(FRAME + 1)) begin
                     bitCnt_d = bitCnt_q + 1'b1;
                  end
               end
               if (sclkFall) begin
                  shiftOut_d = {shiftOut_q[FRAME-2:0], 1'b0};
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase
   end

   // Queue controls pulse only during the single COMMIT cycle.
   assign bus.serve       = (state_q == COMMIT);
   assign bus.hard_msg    = (state_q == COMMIT) && hardMsg;
   assign bus.seize       = (state_q == COMMIT) && readReq;
   assign bus.from_master = fromMaster_q;
   assign bus.spi_miso    = (state_q == ACTIVE) && shiftOut_q[FRAME-1];

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Directed bench for spi_minion_frontend with pack_size=8 (10-bit frames).
module tb_spi_minion_frontend;

   localparam int PS = 8;

   logic clk = 1'b0;
   logic reset;

   int checks   = 0;
   int failures = 0;

   int cycle      = 0;
   int serveCount = 0;
   int seizeCount = 0;
   int pairCount  = 0;
   int serveCycle = 0;
   int riseCycle  = 0;
   logic          lastHard = 1'b0;
   logic [PS-1:0] lastFrom = '0;

   spi_minion_frontend_if #(.pack_size(PS)) bus ();

   spi_minion_frontend #(.pack_size(PS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Records every serve/seize pulse on the falling clock edge.
   always @(negedge clk) begin
      cycle = cycle + 1;
      if (bus.serve === 1'b1) begin
         serveCount = serveCount + 1;
         serveCycle = cycle;
         lastHard   = bus.hard_msg;
         lastFrom   = bus.from_master;
         if (bus.seize === 1'b1) pairCount = pairCount + 1;
      end
      if (bus.seize === 1'b1) seizeCount = seizeCount + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Sends one mode-0 frame, MSB first, capturing MISO before each rising edge.
   task automatic sendFrame(input logic [15:0] frame, input int n,
                            input bit swapTo, input logic [PS-1:0] newTo,
                            output logic [15:0] misoBits);
      misoBits = '0;
      bus.spi_cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < n; i++) begin
         bus.spi_mosi = frame[n-1-i];
         tick(6);
         misoBits[n-1-i] = bus.spi_miso;
         bus.spi_sclk = 1'b1;
         if (swapTo && i == 0) bus.to_master = newTo;
         tick(6);
         bus.spi_sclk = 1'b0;
      end
      tick(6);
      bus.spi_cs_n = 1'b1;
      riseCycle = cycle;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.to_master = '0;
      tick(3);
      reset = 1'b0;
      tick(4);
      checks++; if (bus.serve !== 1'b0) begin failures++; $display("[TB] FAIL reset_serve actual=%b required=0", bus.serve); end
      checks++; if (bus.seize !== 1'b0) begin failures++; $display("[TB] FAIL reset_seize actual=%b required=0", bus.seize); end
      checks++; if (bus.hard_msg !== 1'b0) begin failures++; $display("[TB] FAIL reset_hard actual=%b required=0", bus.hard_msg); end
      checks++; if (bus.spi_miso !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso actual=%b required=0", bus.spi_miso); end
      checks++; if (bus.from_master !== 8'h00) begin failures++; $display("[TB] FAIL reset_from actual=%h required=00", bus.from_master); end
   endtask

   task automatic test_write();
      logic [15:0] miso;
      int s0, z0;
      s0 = serveCount; z0 = seizeCount;
      bus.to_master = 8'h00;
      sendFrame({6'b0, 2'b10, 8'hA5}, 10, 1'b0, 8'h00, miso);
      tick(8);
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL write_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b0) begin failures++; $display("[TB] FAIL write_hard actual=%b required=0", lastHard); end
      checks++; if (lastFrom !== 8'hA5) begin failures++; $display("[TB] FAIL write_from actual=%h required=a5", lastFrom); end
      checks++; if (seizeCount - z0 !== 0) begin failures++; $display("[TB] FAIL write_seize actual=%0d required=0", seizeCount - z0); end
      checks++; if (serveCycle - riseCycle !== 4) begin failures++; $display("[TB] FAIL write_latency actual=%0d required=4", serveCycle - riseCycle); end
      checks++; if (miso[9:0] !== 10'b10_0000_0000) begin failures++; $display("[TB] FAIL write_miso actual=%b required=1000000000", miso[9:0]); end
   endtask

   task automatic test_read();
      logic [15:0] miso;
      int s0, z0;
      s0 = serveCount; z0 = seizeCount;
      bus.to_master = 8'h3C;
      sendFrame({6'b0, 2'b01, 8'h00}, 10, 1'b1, 8'hFF, miso);
      tick(8);
      checks++; if (miso[9:0] !== 10'b10_0011_1100) begin failures++; $display("[TB] FAIL read_miso actual=%b required=1000111100", miso[9:0]); end
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL read_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b1) begin failures++; $display("[TB] FAIL read_hard actual=%b required=1", lastHard); end
      checks++; if (seizeCount - z0 !== 1) begin failures++; $display("[TB] FAIL read_seize actual=%0d required=1", seizeCount - z0); end
      checks++; if (bus.from_master !== 8'hA5) begin failures++; $display("[TB] FAIL read_from actual=%h required=a5", bus.from_master); end
   endtask

   task automatic test_short_long();
      logic [15:0] miso;
      int s0, z0;
      s0 = serveCount; z0 = seizeCount;
      sendFrame({10'b0, 6'b110101}, 6, 1'b0, 8'h00, miso);
      tick(8);
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL short_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b1) begin failures++; $display("[TB] FAIL short_hard actual=%b required=1", lastHard); end
      checks++; if (seizeCount - z0 !== 0) begin failures++; $display("[TB] FAIL short_seize actual=%0d required=0", seizeCount - z0); end
      s0 = serveCount; z0 = seizeCount;
      sendFrame({4'b0, 2'b11, 8'hA5, 2'b11}, 12, 1'b0, 8'h00, miso);
      tick(8);
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL long_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b1) begin failures++; $display("[TB] FAIL long_hard actual=%b required=1", lastHard); end
      checks++; if (seizeCount - z0 !== 0) begin failures++; $display("[TB] FAIL long_seize actual=%0d required=0", seizeCount - z0); end
      checks++; if (bus.from_master !== 8'hA5) begin failures++; $display("[TB] FAIL long_from actual=%h required=a5", bus.from_master); end
   endtask

   task automatic test_combined();
      logic [15:0] miso;
      int s0, z0, p0;
      s0 = serveCount; z0 = seizeCount; p0 = pairCount;
      bus.to_master = 8'hC3;
      sendFrame({6'b0, 2'b11, 8'h5A}, 10, 1'b0, 8'h00, miso);
      tick(8);
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL comb_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b0) begin failures++; $display("[TB] FAIL comb_hard actual=%b required=0", lastHard); end
      checks++; if (lastFrom !== 8'h5A) begin failures++; $display("[TB] FAIL comb_from actual=%h required=5a", lastFrom); end
      checks++; if (seizeCount - z0 !== 1) begin failures++; $display("[TB] FAIL comb_seize actual=%0d required=1", seizeCount - z0); end
      checks++; if (pairCount - p0 !== 1) begin failures++; $display("[TB] FAIL comb_same_cycle actual=%0d required=1", pairCount - p0); end
      checks++; if (miso[9:0] !== {2'b10, 8'hC3}) begin failures++; $display("[TB] FAIL comb_miso actual=%b required=1011000011", miso[9:0]); end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] frame;
      logic [15:0] miso;
      int s0, z0;
      s0 = serveCount; z0 = seizeCount;
      frame = {6'b0, 2'b11, 8'hE1};
      bus.spi_cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
         end
         bus.spi_mosi = frame[9-i];
         tick(6);
         bus.spi_sclk = 1'b1;
         tick(6);
         bus.spi_sclk = 1'b0;
      end
      tick(6);
      bus.spi_cs_n = 1'b1;
      tick(8);
      checks++; if (serveCount - s0 !== 0) begin failures++; $display("[TB] FAIL midrst_serve actual=%0d required=0", serveCount - s0); end
      checks++; if (seizeCount - z0 !== 0) begin failures++; $display("[TB] FAIL midrst_seize actual=%0d required=0", seizeCount - z0); end
      checks++; if (bus.from_master !== 8'h00) begin failures++; $display("[TB] FAIL midrst_from actual=%h required=00", bus.from_master); end
      s0 = serveCount;
      sendFrame({6'b0, 2'b10, 8'h77}, 10, 1'b0, 8'h00, miso);
      tick(8);
      checks++; if (serveCount - s0 !== 1) begin failures++; $display("[TB] FAIL after_rst_serve actual=%0d required=1", serveCount - s0); end
      checks++; if (lastHard !== 1'b0) begin failures++; $display("[TB] FAIL after_rst_hard actual=%b required=0", lastHard); end
      checks++; if (lastFrom !== 8'h77) begin failures++; $display("[TB] FAIL after_rst_from actual=%h required=77", lastFrom); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] miso1;
      logic [15:0] miso2;
      int z0, budget;
      z0 = seizeCount;
      bus.to_master = 8'h11;
      sendFrame({6'b0, 2'b01, 8'h00}, 10, 1'b0, 8'h00, miso1);
      budget = 0;
      while (bus.seize !== 1'b1 && budget < 10) begin
         tick(1);
         budget++;
      end
      checks++; if (bus.seize !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_seize actual=timeout required=pulse"); end
      bus.to_master = 8'h22;
      tick(1);
      sendFrame({6'b0, 2'b01, 8'h00}, 10, 1'b0, 8'h00, miso2);
      tick(8);
      checks++; if (miso1[9:0] !== {2'b10, 8'h11}) begin failures++; $display("[TB] FAIL b2b_miso1 actual=%b required=1000010001", miso1[9:0]); end
      checks++; if (miso2[9:0] !== {2'b10, 8'h22}) begin failures++; $display("[TB] FAIL b2b_miso2 actual=%b required=1000100010", miso2[9:0]); end
      checks++; if (seizeCount - z0 !== 2) begin failures++; $display("[TB] FAIL b2b_seize actual=%0d required=2", seizeCount - z0); end
   endtask

   // Runs every scenario in order, then reports.
   initial begin
      reset = 1'b1;
      bus.spi_cs_n = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.to_master = '0;
      tick(1);
      test_reset();
      test_write();
      test_read();
      test_short_long();
      test_combined();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
